// File: rtl/rategen_pkg.sv
// rategen_pkg: shared constants and helpers for the rate generator bank.
//   DEFAULT_DIV : divisor every channel holds after reset
//   chw(n)      : width of a channel index for n channels (at least 1 bit)
package rategen_pkg;

    localparam int unsigned DEFAULT_DIV = 262144;

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rategen_chan.sv
// rategen_chan: one divider channel of the rate generator bank.
// Counts shared prescaler strobes and emits a one-cycle tick plus a
// toggling square wave every div strobes.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   stb_i        : shared prescaler strobe (already gated by enable)
//   clr_i        : clear counter and square wave, suppress next tick
//   load_i       : load div_i into the divisor register
//   div_i        : new divisor (0 parks the channel)
//   tick_o       : registered one-cycle strobe
//   sq_o         : registered square wave, toggles on each tick
module rategen_chan
    import rategen_pkg::*;
#(
    parameter int          CW          = 19,
    parameter int unsigned DEFAULT_DIV = rategen_pkg::DEFAULT_DIV
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stb_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] div_i,
    output logic          tick_o,
    output logic          sq_o
);

    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          sq_q, sq_d;

    always_comb begin
        div_d  = load_i ? div_i : div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (clr_i) begin
            // Clear also covers a write to this channel; the old divisor
            // must not produce a tick in the cycle after the write.
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (div_q == '0) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (stb_i) begin
            if (cnt_q == div_q - CW'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= CW'(DEFAULT_DIV);
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/rategen_bank.sv
// rategen_bank: shared prescaler feeding NCH programmable divider channels.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : global enable, low freezes prescaler and channel counters
//   sync         : clears prescaler, all channel counters and square waves
//   cfg_we       : divisor write strobe
//   cfg_ch       : target channel of the write
//   cfg_div      : divisor to write (0 disables the channel)
//   cfg_ack      : one-cycle pulse after an accepted write
//   tick, sq     : per-channel tick strobes and square waves
// Write handshake: a write is offered for exactly the cycle cfg_we is high;
// it is always accepted when cfg_ch < NCH (no back-pressure), and cfg_ack
// pulses for one cycle on the following cycle. Writes to cfg_ch >= NCH are
// dropped without an ack. One write per cycle is allowed.
module rategen_bank
    import rategen_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          CW          = 19,
    parameter int          PRESCALE    = 1,
    parameter int unsigned DEFAULT_DIV = rategen_pkg::DEFAULT_DIV,
    localparam int         CHW         = chw(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic           cfg_ack,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq
);

    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

    logic [PCW-1:0] pc_q, pc_d;
    logic           stb;
    logic           ack_q, ack_d;
    logic [31:0]    ch_ext;
    logic           wr_ok;
    logic [NCH-1:0] wr_sel;

    assign stb = en && (pc_q == PC_LAST);

    // sync wins over enable so the prescaler phase restarts from zero.
    always_comb begin
        pc_d = pc_q;
        if (sync || stb) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + PCW'(1);
        end
    end

    // Compare at full integer width so the range check stays meaningful
    // when NCH is not a power of two.
    assign ch_ext = 32'(cfg_ch);
    assign wr_ok  = cfg_we && (ch_ext < 32'(NCH));
    assign ack_d  = wr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            ack_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ack_q <= ack_d;
        end
    end

    assign cfg_ack = ack_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign wr_sel[g] = wr_ok && (ch_ext == 32'(g));

        rategen_chan #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i  (clk),
            .rst_i  (rst),
            .stb_i  (stb),
            .clr_i  (sync || wr_sel[g]),
            .load_i (wr_sel[g]),
            .div_i  (cfg_div),
            .tick_o (tick[g]),
            .sq_o   (sq[g])
        );
    end

endmodule

// File: tb/tb_rategen_bank.sv
module tb_rategen_bank;
    import rategen_pkg::*;

    localparam int NCH      = 3;
    localparam int CW       = 8;
    localparam int PRESCALE = 3;
    localparam int DEF_DIV  = 5;
    localparam int W        = 1 + 2 * NCH;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic           sync = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_ack;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    always #5 clk = ~clk;

    rategen_bank #(
        .NCH         (NCH),
        .CW          (CW),
        .PRESCALE    (PRESCALE),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_ack (cfg_ack),
        .tick    (tick),
        .sq      (sq)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Counts enabled cycles since the last clear and strobes seen by each
    // channel since its last clear; ticks and square-wave level follow
    // from plain division of those counts.
    int e_cnt;
    int k_cnt[NCH];
    int dv[NCH];

    initial begin
        logic           m_stb;
        logic           m_ack;
        logic [NCH-1:0] m_tick;
        logic [NCH-1:0] m_sq;
        forever begin
            @(posedge clk);
            if (rst) begin
                e_cnt = 0;
                for (int i = 0; i < NCH; i++) begin
                    k_cnt[i] = 0;
                    dv[i]    = DEF_DIV;
                end
                exp_q.delete();
            end else begin
                m_stb = 1'b0;
                if (sync) begin
                    e_cnt = 0;
                end else if (en) begin
                    e_cnt = e_cnt + 1;
                    m_stb = (e_cnt % PRESCALE) == 0;
                end
                m_ack  = cfg_we && (int'(cfg_ch) < NCH);
                m_tick = '0;
                m_sq   = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (m_ack && int'(cfg_ch) == i) begin
                        dv[i]    = int'(cfg_div);
                        k_cnt[i] = 0;
                    end else if (sync) begin
                        k_cnt[i] = 0;
                    end else if (dv[i] != 0 && m_stb) begin
                        k_cnt[i] = k_cnt[i] + 1;
                        m_tick[i] = (k_cnt[i] % dv[i]) == 0;
                    end
                    if (dv[i] != 0) m_sq[i] = ((k_cnt[i] / dv[i]) % 2) == 1;
                end
                exp_q.push_back({m_ack, m_sq, m_tick});
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {cfg_ack, sq, tick};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t {ack,sq,tick} act=%b exp=%b", $time, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic write_div(input logic [1:0] ch, input logic [CW-1:0] dv_in, input logic with_sync);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = dv_in;
        sync    = with_sync;
        step(1);
        cfg_we = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            step(1);
            n++;
            if (tick[ch]) ok = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit ok;
        bit bad;
        logic [NCH-1:0] held_sq;

        // Reset state and first period after release.
        step(3);
        check("reset_outputs", 8'({cfg_ack, sq, tick}), 8'd0);
        rst = 1'b0;
        step(14);
        check("cycle14_tick", 8'(tick), 8'd0);
        step(1);
        check("cycle15_tick", 8'(tick), 8'b111);
        check("cycle15_sq", 8'(sq), 8'b111);
        step(15);
        check("cycle30_tick", 8'(tick), 8'b111);
        check("cycle30_sq", 8'(sq), 8'b000);

        // sync together with a write to ch2.
        write_div(2'd2, 8'd2, 1'b1);
        check("sync_wr_ack", 8'(cfg_ack), 8'd1);
        check("sync_wr_tick_n1", 8'(tick), 8'd0);
        step(6);
        check("ch2_tick_n7", 8'(tick), 8'b100);
        step(9);
        check("ch01_tick_n16", 8'(tick), 8'b011);
        check("sq_n16", 8'(sq), 8'b011);

        // Disable ch1 and observe 100 cycles.
        write_div(2'd1, 8'd0, 1'b0);
        check("dis_ack", 8'(cfg_ack), 8'd1);
        bad = 1'b0;
        repeat (100) begin
            step(1);
            if (tick[1] || sq[1]) bad = 1'b1;
        end
        check("ch1_disabled", 8'(bad), 8'd0);
        wait_tick(0, 20, n, ok);
        check("ch0_first_found", 8'(ok), 8'd1);
        wait_tick(0, 20, n, ok);
        check("ch0_period", 8'(n), 8'd15);

        // Enable gap of 10 cycles starting 4 cycles after a tick.
        step(4);
        held_sq = sq;
        en  = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            step(1);
            if (tick != '0 || sq != held_sq) bad = 1'b1;
        end
        en = 1'b1;
        check("gap_quiet_held", 8'(bad), 8'd0);
        wait_tick(0, 30, n, ok);
        check("gap_next_tick", 8'(n + 14), 8'd25);

        // Out-of-range write.
        write_div(2'd3, 8'd1, 1'b0);
        check("bad_ch_no_ack", 8'(cfg_ack), 8'd0);
        wait_tick(0, 20, n, ok);
        wait_tick(0, 20, n, ok);
        check("ch0_period_after_bad", 8'(n), 8'd15);

        // Asynchronous reset between edges.
        step(7);
        rst = 1'b1;
        #1;
        check("async_rst_tick", 8'(tick), 8'd0);
        check("async_rst_sq", 8'(sq), 8'd0);
        check("async_rst_ack", 8'(cfg_ack), 8'd0);
        step(2);
        rst = 1'b0;
        wait_tick(2, 40, n, ok);
        check("ch2_after_reset", 8'(n), 8'd15);

        // Randomized traffic checked by the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            sync    = ($urandom_range(0, 99) == 0);
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_div = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 6));
            step(1);
        end
        en     = 1'b1;
        sync   = 1'b0;
        cfg_we = 1'b0;
        step(3);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rategen_bank.md
# rategen_bank

Multi-channel programmable rate generator: a shared prescaler feeds NCH independent divider channels. Each channel emits a single-cycle `tick` strobe and a toggling square wave `sq`. It replaces the fixed free-running sampling counter. It sits beside the button/display logic, driving debounce sampling, display multiplexing and blink rates from one block. Divisors are runtime-writable through a simple write port with acknowledge.

## Interface
- `NCH`, 4: number of channels (1..16).
- `CW`, 19: channel counter/divisor width.
- `PRESCALE`, 1: shared prescaler ratio, ≥1; 1 = strobe every enabled cycle.
- `DEFAULT_DIV`, 262144: divisor loaded into every channel at reset.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable; low freezes prescaler and all channel counters.
- `sync` in 1: clears prescaler, all channel counters and all `sq` bits.
- `cfg_we` in 1: divisor write strobe.
- `cfg_ch` in CHW = max(1, clog2(NCH)): target channel index.
- `cfg_div` in CW: new divisor; 0 disables the channel.
- `cfg_ack` out 1: one-cycle pulse the cycle after an accepted write.
- `tick` out NCH: per-channel one-cycle strobe, registered.
- `sq` out NCH: per-channel square wave, toggles on each tick, registered.

## Operation
- Prescaler `pc` counts 0..PRESCALE-1 while `en`=1. Internal `stb` = `en && pc==PRESCALE-1`. `pc` wraps to 0 on `stb`.
- Channel i holds `div[i]` and counter `cnt[i]`.
- On `stb` with `div[i]`≠0: if `cnt[i]==div[i]-1`, then `cnt[i]`←0, `tick[i]`←1 next cycle, and `sq[i]` toggles. Otherwise `cnt[i]`++.
- `tick[i]` is 0 in every cycle not following a terminal strobe. It is never high two cycles in a row unless PRESCALE=1 and div=1, in which case it is continuously high.
- `div[i]`=0: `cnt[i]`, `tick[i]` and `sq[i]` are held at 0.
- Write, valid when `cfg_we` and `cfg_ch`<NCH: `div[cfg_ch]`←`cfg_div`, `cnt`←0, `sq`←0, no tick from that channel next cycle, `cfg_ack`←1 next cycle.
- Write with `cfg_ch`≥NCH: ignored, no `cfg_ack`.
- `sync`: `pc`←0, all `cnt`←0, all `sq`←0, no ticks next cycle. It takes priority over `en`/`stb`. `div` is unchanged.
- Write and `sync` in the same cycle: both apply.
- `en`=0: `pc` and `cnt` are frozen; `tick` goes 0 the next cycle; `sq` holds its level.
- Reset, asynchronous: `pc`=0, all `cnt`=0, all `div`=DEFAULT_DIV, `tick`=0, `sq`=0, `cfg_ack`=0. These values appear immediately, without a clock edge.
- Width rule: `cnt` and `div` are CW bits, unsigned. `pc` is clog2(PRESCALE) bits, minimum 1. No overflow is possible since `cnt`<`div`. DEFAULT_DIV must fit in CW bits.

## Timing
- Cycle 0 is the first cycle with cleared state, i.e. after reset release or after a `sync` edge. With `en` held at 1, channel i ticks first at cycle `div*PRESCALE`, then every `div*PRESCALE` cycles.
- `sq` period is 2·`div`·PRESCALE; its first rising edge coincides with the first tick.
- `cfg_ack` latency is 1 cycle. Writes can be issued back-to-back, one per cycle.
- `en` low for K cycles delays every subsequent tick by exactly K cycles.

## Structure
- Package `rategen_pkg`: `DEFAULT_DIV` constant and a `chw(NCH)` index-width function.
- Sub-module `rategen_chan`: one channel, containing the div register, counter, tick/sq registers and load/clear logic. It is instantiated NCH times via generate.
- Top level: prescaler, write decode, `cfg_ack` register.

## Test plan
Bench config: NCH=3, CW=8, PRESCALE=3, DEFAULT_DIV=5, `cfg_ch` 2 bits.
- Release reset with `en`=1 → all `tick` high at cycle 15, 30, 45…; `sq` rises at 15, falls at 30.
- `sync` and write ch2 div=2 at cycle N → `cfg_ack` at N+1; `tick[2]` at N+7, N+13…; ch0/ch1 tick at N+16.
- Write ch1 div=0 → `tick[1]` and `sq[1]` stay 0 for 100 cycles; ch0 period unchanged at 15.
- Drop `en` for 10 cycles starting 4 cycles after a tick → no ticks during the gap; next tick 25 cycles after the previous one; `sq` level held throughout.
- Write with `cfg_ch`=3 → no `cfg_ack`; all channel periods unchanged.
- Assert `rst` mid-period, between clock edges → `tick`/`sq` are 0 before the next edge; after release, ch2 (earlier div=2) ticks at cycle 15, confirming div returned to 5.
